pc_gen: RTL and testbench

Parametrised program-counter generator for the RV32I pipeline's fetch stage. It owns the fetch PC register and selects the next PC each cycle from four sources: sequential increment, branch/jump redirect, trap redirect, and a redirect that arrived while fetch was stalled. A pending-redirect buffer keeps a redirect from being lost while the one-cycle-delay instruction SRAM stalls fetch. A one-cycle boot state makes the first fetch after reset always target the reset vector.

---
 rtl/pc_gen_if.sv | 26 ++
 rtl/pc_gen.sv | 117 +++++++++++
 tb/tb_pc_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-PC control bundle: stall and redirect requests in, fetch PC and status out.
// The master drives the requests; the slave is the PC generator.
interface pc_gen_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                stall_i;
    logic                br_valid_i;
    logic [PC_WIDTH-1:0] br_target_i;
    logic                trap_valid_i;
    logic [PC_WIDTH-1:0] trap_target_i;
    logic [PC_WIDTH-1:0] pc_o;
    logic [PC_WIDTH-1:0] pc_plus_o;
    logic                pc_valid_o;
    logic                redirect_pending_o;
    logic                misalign_o;

    modport master (
        output stall_i, br_valid_i, br_target_i, trap_valid_i, trap_target_i,
        input  pc_o, pc_plus_o, pc_valid_o, redirect_pending_o, misalign_o
    );

    modport slave (
        input  stall_i, br_valid_i, br_target_i, trap_valid_i, trap_target_i,
        output pc_o, pc_plus_o, pc_valid_o, redirect_pending_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential/branch/trap next-PC selection with a
// pending-redirect buffer so redirects survive SRAM stalls and the boot cycle.
module pc_gen #(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned         PC_INC       = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    pc_gen_if.slave bus
);
    typedef enum logic {BOOT, RUN} state_t;

    localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(PC_INC);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_pc_valid;
    logic                r_pend_valid;
    logic                r_pend_is_trap;
    logic [PC_WIDTH-1:0] r_pend_target;
    logic                r_misalign;

    logic                w_hold;
    logic                w_trap_pend;
    logic                w_br_pend;
    logic [PC_WIDTH-1:0] w_pc_plus;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic                w_next_mis;
    logic                w_cap_take;
    logic                w_cap_is_trap;
    logic [PC_WIDTH-1:0] w_cap_target;
    logic                w_cap_mis;

    // Boot and stalled cycles both hold the PC and only feed the pending buffer.
    assign w_hold      = (r_state == BOOT) || bus.stall_i;
    assign w_trap_pend = r_pend_valid && r_pend_is_trap;
    assign w_br_pend   = r_pend_valid && !r_pend_is_trap;
    assign w_pc_plus   = r_pc + INC;

    always_comb begin
        w_next_pc  = w_pc_plus;
        w_next_mis = 1'b0;
        if (bus.trap_valid_i) begin
            w_next_pc  = bus.trap_target_i & ALIGN_MASK;
            w_next_mis = bus.trap_target_i[1];
        end else if (w_trap_pend) begin
            w_next_pc  = r_pend_target;
        end else if (bus.br_valid_i) begin
            w_next_pc  = bus.br_target_i & ALIGN_MASK;
            w_next_mis = bus.br_target_i[1];
        end else if (w_br_pend) begin
            w_next_pc  = r_pend_target;
        end
    end

    // A pending trap is never displaced by a later branch.
    always_comb begin
        w_cap_take    = 1'b0;
        w_cap_is_trap = 1'b0;
        w_cap_target  = r_pend_target;
        w_cap_mis     = 1'b0;
        if (bus.trap_valid_i) begin
            w_cap_take    = 1'b1;
            w_cap_is_trap = 1'b1;
            w_cap_target  = bus.trap_target_i & ALIGN_MASK;
            w_cap_mis     = bus.trap_target_i[1];
        end else if (bus.br_valid_i && !w_trap_pend) begin
            w_cap_take    = 1'b1;
            w_cap_target  = bus.br_target_i & ALIGN_MASK;
            w_cap_mis     = bus.br_target_i[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state        <= BOOT;
            r_pc           <= RESET_VECTOR;
            r_pc_valid     <= 1'b0;
            r_pend_valid   <= 1'b0;
            r_pend_is_trap <= 1'b0;
            r_pend_target  <= RESET_VECTOR;
            r_misalign     <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                default: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
            endcase

            if (w_hold) begin
                if (w_cap_take) begin
                    r_pend_valid   <= 1'b1;
                    r_pend_is_trap <= w_cap_is_trap;
                    r_pend_target  <= w_cap_target;
                end
                r_misalign <= w_cap_mis;
            end else begin
                r_pc         <= w_next_pc;
                r_pend_valid <= 1'b0;
                r_misalign   <= w_next_mis;
            end
        end
    end

    assign bus.pc_o               = r_pc;
    assign bus.pc_plus_o          = w_pc_plus;
    assign bus.pc_valid_o         = r_pc_valid;
    assign bus.redirect_pending_o = r_pend_valid;
    assign bus.misalign_o         = r_misalign;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a directed vector table, hand-written reset/boot
// sequences, and randomized traffic compared against a behavioural model.
module tb_pc_gen;
    localparam int unsigned W  = 32;
    localparam logic [31:0] RV = 32'h100;
    localparam logic [31:0] INC = 32'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.PC_WIDTH(W)) bus();

    pc_gen #(
        .PC_WIDTH    (W),
        .RESET_VECTOR(RV),
        .PC_INC      (4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          stall;
        bit          brv;
        logic [31:0] brt;
        bit          trv;
        logic [31:0] trt;
        logic [31:0] pc;
        bit          valid;
        bit          pend;
        bit          mis;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: where fetch is, and what redirect is waiting.
    bit          mInBoot;
    logic [31:0] mPc;
    bit          mPendV;
    bit          mPendTrap;
    logic [31:0] mPendTgt;
    bit          mMis;

    function automatic vec_t mk(bit s, bit bv, logic [31:0] bt, bit tv, logic [31:0] tt,
                                logic [31:0] pc, bit v, bit p, bit m);
        vec_t r;
        r.stall = s; r.brv = bv; r.brt = bt; r.trv = tv; r.trt = tt;
        r.pc = pc; r.valid = v; r.pend = p; r.mis = m;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] pc, input bit valid,
                            input bit pend, input bit mis);
        checkOutput({tag, ".pc"}, bus.pc_o, pc);
        checkOutput({tag, ".pc_plus"}, bus.pc_plus_o, pc + INC);
        checkOutput({tag, ".valid"}, 32'(bus.pc_valid_o), 32'(valid));
        checkOutput({tag, ".pending"}, 32'(bus.redirect_pending_o), 32'(pend));
        checkOutput({tag, ".misalign"}, 32'(bus.misalign_o), 32'(mis));
    endtask

    task automatic applyStimulus(input bit s, input bit bv, input logic [31:0] bt,
                                 input bit tv, input logic [31:0] tt);
        bus.stall_i       = s;
        bus.br_valid_i    = bv;
        bus.br_target_i   = bt;
        bus.trap_valid_i  = tv;
        bus.trap_target_i = tt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mInBoot = 1'b1; mPc = RV; mPendV = 1'b0; mPendTrap = 1'b0; mPendTgt = '0; mMis = 1'b0;
    endtask

    // One clock of the rules: holding cycles capture into the buffer, free cycles
    // take the highest-priority request from an ordered candidate list.
    task automatic modelStep(input bit s, input bit bv, input logic [31:0] bt,
                             input bit tv, input logic [31:0] tt);
        bit          cv[4];
        logic [31:0] ct[4];
        bit          cm[4];
        bit          found;
        if (mInBoot || s) begin
            mMis = 1'b0;
            if (tv) begin
                mPendV = 1'b1; mPendTrap = 1'b1; mPendTgt = {tt[31:2], 2'b00}; mMis = tt[1];
            end else if (bv && !(mPendV && mPendTrap)) begin
                mPendV = 1'b1; mPendTrap = 1'b0; mPendTgt = {bt[31:2], 2'b00}; mMis = bt[1];
            end
        end else begin
            cv[0] = tv;                   ct[0] = {tt[31:2], 2'b00}; cm[0] = tt[1];
            cv[1] = mPendV && mPendTrap;  ct[1] = mPendTgt;          cm[1] = 1'b0;
            cv[2] = bv;                   ct[2] = {bt[31:2], 2'b00}; cm[2] = bt[1];
            cv[3] = mPendV && !mPendTrap; ct[3] = mPendTgt;          cm[3] = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && cv[k]) begin
                    found = 1'b1; mPc = ct[k]; mMis = cm[k];
                end
            end
            if (!found) begin
                mPc = mPc + INC; mMis = 1'b0;
            end
            mPendV = 1'b0;
        end
        mInBoot = 1'b0;
    endtask

    initial begin
        applyStimulus(0, 0, '0, 0, '0);
        #12;
        checkAll("reset", RV, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h100,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h104,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h108,1,0,0));
        vecs.push_back(mk(0,1,32'h200,0,32'h0,      32'h200,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h204,1,0,0));
        vecs.push_back(mk(1,1,32'h300,0,32'h0,      32'h204,1,1,0));
        vecs.push_back(mk(1,0,32'h0,0,32'h0,        32'h204,1,1,0));
        vecs.push_back(mk(1,0,32'h0,0,32'h0,        32'h204,1,1,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h300,1,0,0));
        vecs.push_back(mk(1,1,32'h400,0,32'h0,      32'h300,1,1,0));
        vecs.push_back(mk(1,0,32'h0,1,32'h80,       32'h300,1,1,0));
        vecs.push_back(mk(1,1,32'h500,0,32'h0,      32'h300,1,1,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h080,1,0,0));
        vecs.push_back(mk(0,1,32'h20A,0,32'h0,      32'h208,1,0,1));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h20C,1,0,0));
        vecs.push_back(mk(0,1,32'h301,0,32'h0,      32'h300,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h304,1,0,0));
        vecs.push_back(mk(1,0,32'h0,0,32'h0,        32'h304,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h308,1,0,0));
        vecs.push_back(mk(0,1,32'h600,1,32'h700,    32'h700,1,0,0));
        vecs.push_back(mk(0,1,32'hFFFFFFF8,0,32'h0, 32'hFFFFFFF8,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'hFFFFFFFC,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h000,1,0,0));
        vecs.push_back(mk(1,0,32'h0,1,32'h90,       32'h000,1,1,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,        32'h090,1,0,0));
        vecs.push_back(mk(1,1,32'h4E,0,32'h0,       32'h090,1,1,1));
        vecs.push_back(mk(1,0,32'h0,0,32'h0,        32'h090,1,1,0));
        vecs.push_back(mk(1,0,32'h0,1,32'hA2,       32'h090,1,1,1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stall, vecs[i].brv, vecs[i].brt, vecs[i].trv, vecs[i].trt);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].pc, vecs[i].valid, vecs[i].pend, vecs[i].mis);
        end

        // Reset mid-stall with a trap pending and misalign high: outputs clear at once.
        applyStimulus(1, 0, '0, 0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("midreset", RV, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, '0, 0, '0);
        tick();
        checkAll("reboot0", RV, 1, 0, 0);
        tick();
        checkAll("reboot1", RV + INC, 1, 0, 0);

        // A branch during BOOT (with stall, which BOOT ignores) is held and applied later.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        applyStimulus(1, 1, 32'h440, 0, '0);
        tick();
        checkAll("bootcap", RV, 1, 1, 0);
        applyStimulus(0, 0, '0, 0, '0);
        tick();
        checkAll("bootapply", 32'h440, 1, 0, 0);

        // Randomized traffic against the behavioural model, with occasional resets.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelReset();
        for (int n = 0; n < 400; n++) begin
            bit          s, bv, tv;
            logic [31:0] bt, tt;
            if ($urandom_range(99) == 0) begin
                rst_n = 1'b0;
                #1;
                modelReset();
                checkAll($sformatf("rnd%0d.reset", n), mPc, !mInBoot, mPendV, mMis);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            s  = ($urandom_range(99) < 35);
            bv = ($urandom_range(99) < 25);
            tv = ($urandom_range(99) < 10);
            bt = ($urandom_range(9) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : $urandom;
            tt = $urandom;
            applyStimulus(s, bv, bt, tv, tt);
            modelStep(s, bv, bt, tv, tt);
            tick();
            checkAll($sformatf("rnd%0d", n), mPc, !mInBoot, mPendV, mMis);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
